call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- WIDTH, 32, data width in bits.
- DEPTH, 8, number of entries; power of two, at least 2.
- SEL_W, 5, width of the Push/Pop selector.
- STACK_SEL, 5'b11110, selector code that addresses the stack.
- PUSH_OFFSET, 4, constant added to DataIn on push (return-address adjust).
- WRAP_MODE, 0, overflow mode: 0 = saturate (reject push when full), 1 = wrap (overwrite oldest entry).
REQ-002 CLK, input, 1: single clock; all state updates on the rising edge.
REQ-003 RST, input, 1: reset, asynchronous, active-low.
REQ-004 Push, input, SEL_W: destination selector; a push is requested when Push == STACK_SEL.
REQ-005 Pop, input, SEL_W: source selector; a pop is requested when Pop == STACK_SEL.
REQ-006 DataIn, input, WIDTH: push data.
REQ-007 DataO, output, WIDTH: current top-of-stack, always driven (no tri-state).
REQ-008 Count, output, $clog2(DEPTH)+1: number of valid entries.
REQ-009 Empty, output, 1: high when Count == 0.
REQ-010 Full, output, 1: high when Count == DEPTH.
REQ-011 Overflow, output, 1: one-cycle pulse when a push hits a full stack.
REQ-012 Underflow, output, 1: one-cycle pulse when a pop hits an empty stack.

Function
REQ-013 DataO SHALL be combinational from registered state: the top entry when non-empty, 0 when Empty.
- A pop consumer samples DataO in the same cycle Pop is asserted.
REQ-014 Push-only with Count < DEPTH SHALL do all of the following at the next edge:
- write DataIn + PUSH_OFFSET, truncated modulo 2^WIDTH;
- make that entry the new top;
- increment Count.
REQ-015 Pop-only with Count > 0 SHALL remove the top entry and decrement Count; the new DataO is the previous second entry.
REQ-016 Push and pop both requested with Count > 0 SHALL replace the top with DataIn + PUSH_OFFSET; Count is unchanged and no flag pulses.
REQ-017 Push and pop both requested with Count == 0 SHALL act as push-only; Underflow stays low.
REQ-018 Push-only with Full and WRAP_MODE=0 SHALL leave storage and Count unchanged and pulse Overflow.
REQ-019 Push-only with Full and WRAP_MODE=1 SHALL discard the oldest entry, push the new value, keep Count == DEPTH, and pulse Overflow.
REQ-020 Pop with Empty SHALL leave state unchanged, keep DataO = 0, and pulse Underflow.
REQ-021 Overflow and Underflow SHALL be registered and high for exactly the cycle after the offending edge; they never assert together.
REQ-022 With neither request asserted, state SHALL hold.
REQ-023 Storage SHALL be a circular buffer: a top pointer of $clog2(DEPTH) bits wraps modulo DEPTH, and Count saturates at DEPTH.

Reset
REQ-024 RST low SHALL immediately clear the following:
- Count = 0, Empty = 1, Full = 0;
- DataO = 0;
- Overflow = 0, Underflow = 0;
- the top pointer.
Entry contents need not be cleared.
REQ-025 A request in the cycle RST deasserts SHALL be honoured at the first rising edge with RST high.
REQ-026 Reset mid-sequence SHALL discard all entries; no stale entry is ever visible on DataO afterwards.

Structure
REQ-027 Package stack_pkg SHALL hold the STACK_SEL default code and the WRAP_MODE encodings (SAT=0, WRAP=1).
REQ-028 Entry storage SHALL be one sub-module, stack_mem: a DEPTH x WIDTH register array with one write port, indexed by pointer, and an asynchronous read of the top entry.
- Pointer/count control stays in call_stack.

Verification (WIDTH=32, DEPTH=4, OFFSET=4)
REQ-029 Reset, then push 0x100, 0x200 -> DataO=0x204, Count=2; pop -> DataO=0x104; pop -> DataO=0, Empty=1.
REQ-030 Push 4 values with WRAP_MODE=0 -> Full=1; a 5th push of 0x500 -> Overflow pulse, DataO unchanged, Count=4.
REQ-031 WRAP_MODE=1, push 0x10, 0x20, 0x30, 0x40, 0x50 -> Overflow pulse, Count=4; four pops return 0x54, 0x44, 0x34, 0x24, then Empty.
REQ-032 Pop on empty -> Underflow for one cycle, Count=0, DataO=0; simultaneous push 0x80 + pop on empty -> DataO=0x84, Count=1, no Underflow.
REQ-033 With Count=2, simultaneous push 0x300 + pop -> top=0x304, Count=2; Push=5'b00011 with Pop=5'b11110 -> pop only.
REQ-034 Push 0xFFFFFFFE -> DataO=0x00000002 (wrap); assert RST mid-stream with Count=3 -> Count=0, DataO=0 immediately, before any clock edge.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants for the call stack
package stack_pkg;

  localparam logic [4:0] STACK_SEL_DEF = 5'b11110;

  typedef enum logic {
    SAT  = 1'b0,
    WRAP = 1'b1
  } wrap_mode_e;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH entry storage, one write port, async top read
module stack_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately unreset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// rtl/call_stack.sv - return-address stack over a circular buffer
module call_stack
  import stack_pkg::*;
#(
  parameter int                WIDTH       = 32,
  parameter int                DEPTH       = 8,
  parameter int                SEL_W       = 5,
  parameter logic [SEL_W-1:0]  STACK_SEL   = SEL_W'(STACK_SEL_DEF),
  parameter int                PUSH_OFFSET = 4,
  parameter int                WRAP_MODE   = MODE_SAT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [SEL_W-1:0]           Push,
  input  logic [SEL_W-1:0]           Pop,
  input  logic [WIDTH-1:0]           DataIn,
  output logic [WIDTH-1:0]           DataO,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty,
  output logic                       Full,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    ptr, ptr_nxt, waddr;
  logic [CW-1:0]    cnt_nxt;
  logic             we, ov_nxt, un_nxt;
  logic             push_req, pop_req;
  logic [WIDTH-1:0] push_val, top_data;

  assign push_req = (Push == STACK_SEL);
  assign pop_req  = (Pop == STACK_SEL);
  assign push_val = DataIn + WIDTH'(PUSH_OFFSET);
  assign Empty    = (Count == '0);
  assign Full     = (Count == CW'(DEPTH));

  // ptr addresses the current top; a push lands one slot above it, which
  // on a full stack is exactly the oldest entry (the wrap-mode victim).
  always_comb begin
    we      = 1'b0;
    waddr   = ptr + PW'(1);
    ptr_nxt = ptr;
    cnt_nxt = Count;
    ov_nxt  = 1'b0;
    un_nxt  = 1'b0;
    if (push_req && pop_req && !Empty) begin
      we    = 1'b1;
      waddr = ptr;
    end else if (push_req) begin
      if (!Full) begin
        we      = 1'b1;
        ptr_nxt = ptr + PW'(1);
        cnt_nxt = Count + CW'(1);
      end else begin
        ov_nxt = 1'b1;
        if (WRAP_MODE == MODE_WRAP) begin
          we      = 1'b1;
          ptr_nxt = ptr + PW'(1);
        end
      end
    end else if (pop_req) begin
      if (!Empty) begin
        ptr_nxt = ptr - PW'(1);
        cnt_nxt = Count - CW'(1);
      end else begin
        un_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr       <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      Count     <= cnt_nxt;
      Overflow  <= ov_nxt;
      Underflow <= un_nxt;
    end
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (we),
    .waddr (waddr),
    .wdata (push_val),
    .raddr (ptr),
    .rdata (top_data)
  );

  // Gating on Empty keeps stale entries invisible after reset or full drain.
  assign DataO = Empty ? '0 : top_data;

endmodule

// File: tb/tb_call_stack.sv
// tb/tb_call_stack.sv - randomized and directed check of call_stack against a queue model
module tb_call_stack;
  import stack_pkg::*;

  localparam int D = 4;
  localparam logic [4:0] SEL = 5'b11110;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  Push = '0;
  logic [4:0]  Pop = '0;
  logic [31:0] DataIn = '0;

  logic [31:0] dout [2];
  logic [2:0]  cnt  [2];
  logic        emp  [2];
  logic        ful  [2];
  logic        ovf  [2];
  logic        unf  [2];

  int total = 0;
  int bad   = 0;

  logic [31:0] qs[$];
  logic [31:0] qw[$];
  logic        exp_ov [2];
  logic        exp_un [2];

  always #5 CLK = ~CLK;

  call_stack #(.WIDTH(32), .DEPTH(D), .SEL_W(5), .STACK_SEL(SEL), .PUSH_OFFSET(4), .WRAP_MODE(0)) u_sat (
    .CLK(CLK), .RST(RST), .Push(Push), .Pop(Pop), .DataIn(DataIn),
    .DataO(dout[0]), .Count(cnt[0]), .Empty(emp[0]), .Full(ful[0]),
    .Overflow(ovf[0]), .Underflow(unf[0])
  );

  call_stack #(.WIDTH(32), .DEPTH(D), .SEL_W(5), .STACK_SEL(SEL), .PUSH_OFFSET(4), .WRAP_MODE(1)) u_wrap (
    .CLK(CLK), .RST(RST), .Push(Push), .Pop(Pop), .DataIn(DataIn),
    .DataO(dout[1]), .Count(cnt[1]), .Empty(emp[1]), .Full(ful[1]),
    .Overflow(ovf[1]), .Underflow(unf[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [31:0] q[$];
      logic [31:0] top;
      if (m == 0) q = qs; else q = qw;
      top = (q.size() > 0) ? q[q.size()-1] : 32'h0;
      check($sformatf("%s/m%0d/data", tag, m), dout[m], top);
      check($sformatf("%s/m%0d/count", tag, m), {29'b0, cnt[m]}, q.size());
      check($sformatf("%s/m%0d/empty", tag, m), {31'b0, emp[m]}, {31'b0, q.size() == 0});
      check($sformatf("%s/m%0d/full", tag, m), {31'b0, ful[m]}, {31'b0, q.size() == D});
      check($sformatf("%s/m%0d/ovf", tag, m), {31'b0, ovf[m]}, {31'b0, exp_ov[m]});
      check($sformatf("%s/m%0d/unf", tag, m), {31'b0, unf[m]}, {31'b0, exp_un[m]});
    end
  endtask

  task automatic model(input logic ps, input logic pp, input logic [31:0] din);
    logic [31:0] v;
    v = din + 32'd4;
    for (int m = 0; m < 2; m++) begin
      logic [31:0] q[$];
      if (m == 0) q = qs; else q = qw;
      exp_ov[m] = 1'b0;
      exp_un[m] = 1'b0;
      if (ps && pp && q.size() > 0) begin
        q[q.size()-1] = v;
      end else if (ps) begin
        if (q.size() < D) begin
          q.push_back(v);
        end else begin
          exp_ov[m] = 1'b1;
          if (m == 1) begin
            void'(q.pop_front());
            q.push_back(v);
          end
        end
      end else if (pp) begin
        if (q.size() > 0) void'(q.pop_back());
        else exp_un[m] = 1'b1;
      end
      if (m == 0) qs = q; else qw = q;
    end
  endtask

  task automatic op(input logic [4:0] ps, input logic [4:0] pp, input logic [31:0] din, input string tag);
    Push = ps;
    Pop = pp;
    DataIn = din;
    @(posedge CLK);
    #1;
    model(ps == SEL, pp == SEL, din);
    check_all(tag);
    Push = '0;
    Pop = '0;
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b0;
    #1;
    qs.delete();
    qw.delete();
    exp_ov = '{1'b0, 1'b0};
    exp_un = '{1'b0, 1'b0};
    check_all(tag);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    exp_ov = '{1'b0, 1'b0};
    exp_un = '{1'b0, 1'b0};
    #2;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b1;

    // basic push/pop
    op(SEL, 5'd0, 32'h100, "p100");
    op(SEL, 5'd0, 32'h200, "p200");
    check("top204", dout[0], 32'h204);
    op(5'd0, SEL, 32'h0, "pop1");
    check("top104", dout[0], 32'h104);
    op(5'd0, SEL, 32'h0, "pop2");
    op(5'd0, 5'd0, 32'h0, "idle");

    // fill and overflow
    for (int i = 1; i <= 4; i++) op(SEL, 5'd0, 32'(i) << 8, "fill");
    op(SEL, 5'd0, 32'h500, "ovf5");
    check("sat_top", dout[0], 32'h404);
    check("wrap_top", dout[1], 32'h504);
    op(5'd0, 5'd0, 32'h0, "ovf_drop");

    // wrap-mode oldest discard
    do_reset("rst_a");
    for (int i = 1; i <= 5; i++) op(SEL, 5'd0, 32'(i) << 4, "wfill");
    for (int i = 0; i < 4; i++) op(5'd0, SEL, 32'h0, "wpop");
    op(5'd0, SEL, 32'h0, "unf");
    op(5'd0, 5'd0, 32'h0, "unf_drop");
    op(SEL, SEL, 32'h80, "pp_empty");
    check("pp_top", dout[1], 32'h84);

    // replace and non-matching selector
    op(SEL, 5'd0, 32'h90, "p90");
    op(SEL, SEL, 32'h300, "replace");
    check("rep_top", dout[0], 32'h304);
    op(5'b00011, SEL, 32'h777, "sel_miss");

    // arithmetic wrap and async reset mid-stream
    op(SEL, 5'd0, 32'hFFFF_FFFE, "pwrap");
    check("wrap_val", dout[0], 32'h2);
    op(SEL, 5'd0, 32'h40, "p40");
    RST = 1'b0;
    #1;
    check("async_cnt", {29'b0, cnt[0]}, 32'h0);
    check("async_data", dout[1], 32'h0);
    qs.delete();
    qw.delete();
    exp_ov = '{1'b0, 1'b0};
    exp_un = '{1'b0, 1'b0};
    check_all("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    op(SEL, 5'd0, 32'h600, "post_rst");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  ps, pp;
      logic [31:0] d;
      ps = ($urandom_range(0, 2) != 0) ? SEL : 5'($urandom);
      pp = ($urandom_range(0, 1) != 0) ? SEL : 5'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
      op(ps, pp, d, "rand");
      if (i % 97 == 96) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
